// File: rtl/fmadd_pkg.sv
// Shared constants and FSM state type for the FMADD datapath stages.
package fmadd_pkg;

   localparam int unsigned STD    = 31;
   localparam int unsigned MAN    = 22;
   localparam int unsigned EXP    = 7;
   localparam int unsigned BIAS   = (2 ** EXP) - 1;
   localparam int unsigned PROD_W = 2 + EXP + 2 * (MAN + 2);

   typedef enum logic [1:0] {
      StIdle,
      StBusy,
      StDone
   } state_t;

endpackage

// File: rtl/fmadd_iter_multiplier_if.sv
// Operand/product handshake bundle of the iterative FMADD multiplier.
interface fmadd_iter_multiplier_if #(
   parameter int unsigned Std = fmadd_pkg::STD,
   parameter int unsigned Man = fmadd_pkg::MAN,
   parameter int unsigned Exp = fmadd_pkg::EXP
);

   logic                        valid_in;
   logic                        ready_out;
   logic [Std:0]                op_a;
   logic [Std:0]                op_b;
   logic                        valid_out;
   logic                        ready_in;
   logic [1+Exp+2*(Man+2):0]    prod_out;
   logic                        ovf_out;
   logic                        unf_out;

   modport master (
      output valid_in, op_a, op_b, ready_in,
      input  ready_out, valid_out, prod_out, ovf_out, unf_out
   );

   modport slave (
      input  valid_in, op_a, op_b, ready_in,
      output ready_out, valid_out, prod_out, ovf_out, unf_out
   );

endinterface

// File: rtl/fmadd_exp_unit.sv
// Product sign, re-biased exponent sum and overflow/underflow flags (combinational).
module fmadd_exp_unit #(
   parameter int unsigned Exp = fmadd_pkg::EXP
) (
   input  logic         sign_a_i,
   input  logic         sign_b_i,
   input  logic [Exp:0] exp_a_i,
   input  logic [Exp:0] exp_b_i,
   output logic         sign_o,
   output logic [Exp:0] exp_o,
   output logic         ovf_o,
   output logic         unf_o
);

   localparam logic [Exp+2:0] BiasW = {3'b000, {Exp{1'b1}}};

   logic [Exp+2:0] sum;

   always_comb begin
      sign_o = sign_a_i ^ sign_b_i;
      sum    = {2'b00, exp_a_i} + {2'b00, exp_b_i} - BiasW;
      // Two's complement in Exp+3 bits: MSB is the sign, positive range never reaches it.
      unf_o  = sum[Exp+2] | (sum == '0);
      ovf_o  = ~sum[Exp+2] & (sum[Exp+1] | (&sum[Exp:0]));
      if (ovf_o) begin
         exp_o = '1;
      end else if (unf_o) begin
         exp_o = '0;
      end else begin
         exp_o = sum[Exp:0];
      end
   end

endmodule

// File: rtl/fmadd_iter_multiplier.sv
// Radix-2 shift-add significand multiplier producing the unnormalised wide product.
// Optional FMUL_EARLY_EXIT_EN: finish as soon as no multiplier bits remain.
module fmadd_iter_multiplier
   import fmadd_pkg::*;
#(
   parameter int unsigned Std = STD,
   parameter int unsigned Man = MAN,
   parameter int unsigned Exp = EXP
) (
   input  logic                     clk,
   input  logic                     rst_l,
   fmadd_iter_multiplier_if.slave   bus
);

   localparam int unsigned SigW = Man + 2;
   localparam int unsigned AccW = 2 * SigW;
   localparam int unsigned CntW = $clog2(SigW);

   state_t              state_q;
   logic [SigW-1:0]     mcand_q;
   logic [SigW-1:0]     mplier_q;
   logic [AccW-1:0]     acc_q;
   logic [CntW-1:0]     cnt_q;
   logic                sign_q;
   logic [Exp:0]        exp_q;
   logic                ovf_q;
   logic                unf_q;
   logic                valid_q;
   logic [1+Exp+AccW:0] prod_q;
   logic                ovf_out_q;
   logic                unf_out_q;

   logic                ready;
   logic                accept;
   logic [SigW-1:0]     sig_a;
   logic [SigW-1:0]     sig_b;
   logic [AccW-1:0]     acc_next;
   logic                finish;
   logic                sign_c;
   logic [Exp:0]        exp_c;
   logic                ovf_c;
   logic                unf_c;

   fmadd_exp_unit #(
      .Exp (Exp)
   ) u_exp_unit (
      .sign_a_i (bus.op_a[Std]),
      .sign_b_i (bus.op_b[Std]),
      .exp_a_i  (bus.op_a[Std-1 -: Exp+1]),
      .exp_b_i  (bus.op_b[Std-1 -: Exp+1]),
      .sign_o   (sign_c),
      .exp_o    (exp_c),
      .ovf_o    (ovf_c),
      .unf_o    (unf_c)
   );

   always_comb begin
      ready    = (state_q == StIdle) | ((state_q == StDone) & bus.ready_in);
      accept   = bus.valid_in & ready;
      // Denormals carry a zero hidden bit.
      sig_a    = {|bus.op_a[Std-1 -: Exp+1], bus.op_a[Man:0]};
      sig_b    = {|bus.op_b[Std-1 -: Exp+1], bus.op_b[Man:0]};
      acc_next = acc_q;
      if (mplier_q[0]) begin
         acc_next = acc_q + (AccW'(mcand_q) << cnt_q);
      end
`ifdef FMUL_EARLY_EXIT_EN
      finish = (cnt_q == CntW'(Man + 1)) | (mcand_q == '0) | (mplier_q[SigW-1:1] == '0);
`else
      finish = (cnt_q == CntW'(Man + 1));
`endif
   end

   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         state_q   <= StIdle;
         mcand_q   <= '0;
         mplier_q  <= '0;
         acc_q     <= '0;
         cnt_q     <= '0;
         sign_q    <= 1'b0;
         exp_q     <= '0;
         ovf_q     <= 1'b0;
         unf_q     <= 1'b0;
         valid_q   <= 1'b0;
         prod_q    <= '0;
         ovf_out_q <= 1'b0;
         unf_out_q <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: ;
            StBusy: begin
               acc_q    <= acc_next;
               mplier_q <= mplier_q >> 1;
               cnt_q    <= cnt_q + 1'b1;
               if (finish) begin
                  state_q   <= StDone;
                  valid_q   <= 1'b1;
                  prod_q    <= {sign_q, exp_q, acc_next};
                  ovf_out_q <= ovf_q;
                  unf_out_q <= unf_q;
               end
            end
            StDone: begin
               if (bus.ready_in) begin
                  state_q <= StIdle;
                  valid_q <= 1'b0;
               end
            end
            default: state_q <= StIdle;
         endcase
         // Acceptance overrides the DONE->IDLE move so back-to-back pairs skip IDLE.
         if (accept) begin
            state_q  <= StBusy;
            mcand_q  <= sig_a;
            mplier_q <= sig_b;
            acc_q    <= '0;
            cnt_q    <= '0;
            sign_q   <= sign_c;
            exp_q    <= exp_c;
            ovf_q    <= ovf_c;
            unf_q    <= unf_c;
         end
      end
   end

   assign bus.ready_out = ready;
   assign bus.valid_out = valid_q;
   assign bus.prod_out  = prod_q;
   assign bus.ovf_out   = ovf_out_q;
   assign bus.unf_out   = unf_out_q;

endmodule

// File: tb/tb_fmadd_iter_multiplier.sv
// Randomised and directed bench for fmadd_iter_multiplier against an arithmetic reference model.
module tb_fmadd_iter_multiplier;
   import fmadd_pkg::*;

   logic clk = 1'b0;
   logic rst_l = 1'b0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   fmadd_iter_multiplier_if bus ();

   fmadd_iter_multiplier dut (
      .clk   (clk),
      .rst_l (rst_l),
      .bus   (bus)
   );

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
      end
   endtask

   function automatic longint unsigned sig_of(input logic [31:0] x);
      longint unsigned s;
      s = longint'(x[22:0]);
      if (x[30:23] != 8'd0) s = s + (64'd1 << 23);
      return s;
   endfunction

   // Returns {ovf, unf, sign, exponent, 48-bit mantissa product}.
   function automatic logic [PROD_W+1:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
      int              e;
      logic            ovf;
      logic            unf;
      logic [7:0]      ef;
      longint unsigned m;
      e   = int'(a[30:23]) + int'(b[30:23]) - int'(BIAS);
      ovf = (e >= 255);
      unf = (e <= 0);
      ef  = ovf ? 8'hFF : (unf ? 8'h00 : 8'(e));
      m   = sig_of(a) * sig_of(b);
      return {ovf, unf, a[31] ^ b[31], ef, m[47:0]};
   endfunction

   function automatic int ref_lat(input logic [31:0] a, input logic [31:0] b);
`ifdef FMUL_EARLY_EXIT_EN
      longint unsigned sb;
      sb = sig_of(b);
      if (sig_of(a) == 0 || sb == 0) return 1;
      for (int k = 23; k >= 0; k--) begin
         if (sb[k]) return k + 1;
      end
      return 1;
`else
      return MAN + 2;
`endif
   endfunction

   task automatic send(input logic [31:0] a, input logic [31:0] b);
      int n;
      bus.valid_in = 1'b1;
      bus.op_a     = a;
      bus.op_b     = b;
      n = 0;
      while (!bus.ready_out && n < 100) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (n == 100) check_eq("accept_timeout", 64'(bus.ready_out), 64'd1);
      @(posedge clk);
      #1;
      bus.valid_in = 1'b0;
   endtask

   task automatic collect(input logic [31:0] a, input logic [31:0] b, input int bp);
      logic [PROD_W+1:0] r;
      int                lat;
      r   = ref_mul(a, b);
      lat = 0;
      while (!bus.valid_out && lat < 100) begin
         @(posedge clk);
         #1;
         lat++;
      end
      check_eq("latency", 64'(lat), 64'(ref_lat(a, b)));
      check_eq("prod", 64'(bus.prod_out), 64'(r[PROD_W-1:0]));
      check_eq("ovf", 64'(bus.ovf_out), 64'(r[PROD_W+1]));
      check_eq("unf", 64'(bus.unf_out), 64'(r[PROD_W]));
      bus.ready_in = 1'b0;
      for (int i = 0; i < bp; i++) begin
         @(posedge clk);
         #1;
         check_eq("bp_prod_stable", 64'(bus.prod_out), 64'(r[PROD_W-1:0]));
         check_eq("bp_valid_held", 64'(bus.valid_out), 64'd1);
         check_eq("bp_ready_low", 64'(bus.ready_out), 64'd0);
      end
   endtask

   task automatic release_out();
      bus.ready_in = 1'b1;
      @(posedge clk);
      #1;
      bus.ready_in = 1'b0;
      check_eq("release_valid_low", 64'(bus.valid_out), 64'd0);
   endtask

   // Hands over the finished product and offers a new pair on the same edge.
   task automatic chain(input logic [31:0] a, input logic [31:0] b);
      bus.valid_in = 1'b1;
      bus.op_a     = a;
      bus.op_b     = b;
      bus.ready_in = 1'b1;
      #1;
      check_eq("chain_ready", 64'(bus.ready_out), 64'd1);
      @(posedge clk);
      #1;
      bus.valid_in = 1'b0;
      bus.ready_in = 1'b0;
      check_eq("chain_valid_low", 64'(bus.valid_out), 64'd0);
      check_eq("chain_busy", 64'(bus.ready_out), 64'd0);
   endtask

   function automatic logic [31:0] rand_op();
      logic [31:0] x;
      x = $urandom;
      if ($urandom_range(0, 3) == 0) x[30:23] = 8'd0;
      if ($urandom_range(0, 7) == 0) x[22:0] = 23'd0;
      return x;
   endfunction

   logic [31:0] da [5] = '{32'h3F800000, 32'h40000000, 32'h7F000000, 32'h00800000, 32'h00000000};
   logic [31:0] db [5] = '{32'h3F800000, 32'hC0400000, 32'h7F000000, 32'h00800000, 32'h3F800000};

   initial begin
      logic [31:0] ca, cb, na, nb;
      int          seen;
      bus.valid_in = 1'b0;
      bus.ready_in = 1'b0;
      bus.op_a     = '0;
      bus.op_b     = '0;
      #3;
      check_eq("rst_valid", 64'(bus.valid_out), 64'd0);
      check_eq("rst_prod", 64'(bus.prod_out), 64'd0);
      check_eq("rst_ovf", 64'(bus.ovf_out), 64'd0);
      check_eq("rst_unf", 64'(bus.unf_out), 64'd0);
      check_eq("rst_ready", 64'(bus.ready_out), 64'd1);
      @(negedge clk);
      rst_l = 1'b1;
      @(posedge clk);
      #1;

      // 1.0x1.0 under 5 cycles of backpressure, then chained straight into 2.0x-3.0.
      send(da[0], db[0]);
      collect(da[0], db[0], 5);
      chain(da[1], db[1]);
      collect(da[1], db[1], 0);
      release_out();
      for (int i = 2; i < 5; i++) begin
         send(da[i], db[i]);
         collect(da[i], db[i], 1);
         release_out();
      end

      // Reset in the middle of a BUSY run.
      send(32'h3F800000, 32'h40400000);
      repeat (10) @(posedge clk);
      #1;
      rst_l = 1'b0;
      #1;
      check_eq("abort_valid", 64'(bus.valid_out), 64'd0);
      check_eq("abort_prod", 64'(bus.prod_out), 64'd0);
      check_eq("abort_ready", 64'(bus.ready_out), 64'd1);
      @(negedge clk);
      rst_l = 1'b1;
      seen = 0;
      repeat (30) begin
         @(posedge clk);
         #1;
         if (bus.valid_out) seen++;
      end
      check_eq("abort_no_output", 64'(seen), 64'd0);
      send(32'h40400000, 32'hBFC00000);
      collect(32'h40400000, 32'hBFC00000, 0);
      release_out();

      // Random pairs, randomly chained back-to-back or released through IDLE.
      ca = rand_op();
      cb = rand_op();
      send(ca, cb);
      for (int i = 0; i < 30; i++) begin
         collect(ca, cb, $urandom_range(0, 3));
         na = rand_op();
         nb = rand_op();
         if ($urandom_range(0, 1) == 1) begin
            chain(na, nb);
         end else begin
            release_out();
            send(na, nb);
         end
         ca = na;
         cb = nb;
      end
      collect(ca, cb, 0);
      release_out();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
